// File: rtl/spi_slave_regfile.sv
// SPI responder for 12-bit {rw, addr, data} frames backed by a register file shared with a local port.
// Define SPI_SLV_FRAME_ERR_EN to add the frame_err abort-detect output.
module spi_slave_regfile #(
  parameter int RW_FLAG     = 1,
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int CMD_WIDTH   = RW_FLAG + ADDR_WIDTH + DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  lcl_wr_en,
  input  logic [ADDR_WIDTH-1:0] lcl_wr_addr,
  input  logic [DATA_WIDTH-1:0] lcl_wr_data,
  input  logic [ADDR_WIDTH-1:0] lcl_rd_addr,
  output logic [DATA_WIDTH-1:0] lcl_rd_data
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  // state   | meaning
  // IDLE    | waiting for cs low
  // CMD     | shifting in the command frame on sclk rise
  // RD_WAIT | read data MSB on miso, waiting out the master turnaround
  // RD_DATA | shifting read data out on sclk fall
  // DONE    | frame finished, ignore sclk until cs rises
  typedef enum logic [2:0] {IDLE, CMD, RD_WAIT, RD_DATA, DONE} state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(CMD_WIDTH + 1);

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CMD_WIDTH-2:0]    cmd_sr;
  logic [DATA_WIDTH-1:0]   rd_sr;
  logic [DATA_WIDTH-1:0]   regfile [DEPTH];

  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_d;
  logic                    sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

  logic [CMD_WIDTH-1:0]    cmd_next;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [DATA_WIDTH-1:0]   snapshot;
  logic [DATA_WIDTH-1:0]   rd_shift;

  // cs synchronizer resets to the idle-high level so reset never looks like a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // cmd_sr holds all but the newest bit; the full frame is assembled on the final rise
  assign cmd_next    = {cmd_sr, mosi_s};
  assign cmd_addr    = cmd_next[DATA_WIDTH +: ADDR_WIDTH];
  assign cmd_data    = cmd_next[DATA_WIDTH-1:0];
  assign snapshot    = regfile[cmd_addr];
  assign rd_shift    = rd_sr << 1;
  assign lcl_rd_data = regfile[lcl_rd_addr];

  // SPI commit is applied after the local write so it wins on an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
    end else begin
      if (lcl_wr_en) regfile[lcl_wr_addr] <= lcl_wr_data;
      if (wr_valid)  regfile[wr_addr]     <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      rd_sr     <= '0;
      miso      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
`ifdef SPI_SLV_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      wr_valid  <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (cs_s) begin
`ifdef SPI_SLV_FRAME_ERR_EN
        frame_err <= (state == CMD && bit_cnt != '0) ||
                     state == RD_WAIT || state == RD_DATA;
`endif
        state <= IDLE;
        miso  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            state   <= CMD;
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_sr  <= cmd_next[CMD_WIDTH-2:0];
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(CMD_WIDTH - 1)) begin
                if (cmd_next[CMD_WIDTH-1]) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= cmd_addr;
                  wr_data  <= cmd_data;
                  state    <= DONE;
                end else begin
                  rd_sr <= snapshot;
                  miso  <= snapshot[DATA_WIDTH-1];
                  state <= RD_WAIT;
                end
              end
            end
          end
          RD_WAIT: begin
            if (sclk_rise) begin
              bit_cnt <= CNT_W'(1);
              state   <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (sclk_fall) begin
              rd_sr <= rd_shift;
              miso  <= rd_shift[DATA_WIDTH-1];
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                state <= DONE;
                miso  <= 1'b0;
              end
            end
          end
          DONE: miso <= 1'b0;
          default: begin
            state <= IDLE;
            miso  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
